// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcodes, funct codes,
// the execute bundle and instruction field slicers.
package id_stage_pkg;

  localparam int W = 32;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADDI  = 3'b000,
    F3_SLLI  = 3'b001,
    F3_SLTI  = 3'b010,
    F3_SLTIU = 3'b011,
    F3_XORI  = 3'b100,
    F3_SRI   = 3'b101,
    F3_ORI   = 3'b110,
    F3_ANDI  = 3'b111
  } f3OpI;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic         op;
    logic         op_imm;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   rd;
    logic         rd_we;
    logic [W-1:0] pc;
    logic         illegal;
  } ex_bundle_t;

  function automatic logic [6:0] f_opcode(input logic [31:0] i); return i[6:0];   endfunction
  function automatic logic [4:0] f_rd    (input logic [31:0] i); return i[11:7];  endfunction
  function automatic logic [2:0] f_funct3(input logic [31:0] i); return i[14:12]; endfunction
  function automatic logic [4:0] f_rs1   (input logic [31:0] i); return i[19:15]; endfunction
  function automatic logic [4:0] f_rs2   (input logic [31:0] i); return i[24:20]; endfunction
  function automatic logic [6:0] f_funct7(input logic [31:0] i); return i[31:25]; endfunction
  function automatic logic [31:0] imm_i(input logic [31:0] i); return {{20{i[31]}}, i[31:20]}; endfunction
  function automatic logic [31:0] imm_u(input logic [31:0] i); return {i[31:12], 12'b0}; endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 2R1W register file: async reads, sync write, x0 hardwired zero, write-through
// bypass. Indices at or above NREG read 0 and are never written.
module regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic            wr_ok;

  assign wr_ok = we && (wa != 5'd0) && (int'(wa) < NREG);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0 && int'(ra1) < NREG)
      rd1 = (wr_ok && wa == ra1) ? wd : mem[ra1[AW-1:0]];
    if (ra2 != 5'd0 && int'(ra2) < NREG)
      rd2 = (wr_ok && wa == ra2) ? wd : mem[ra2[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa[AW-1:0]] <= wd;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes one instruction per handshake into a registered
// ALU bundle. Define RV32E_EN for the 16-register RV32E variant.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic            ex_op,
  output logic            ex_op_imm,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

`ifdef RV32E_EN
  localparam int NR = (NREG > 16) ? 16 : NREG;
`else
  localparam int NR = NREG;
`endif

  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2, rd;
  logic            legal, legal_fmt, cap, vld_q;
  ex_bundle_t      dec, ex_q;

  assign opc = f_opcode(if_inst);
  assign f3  = f_funct3(if_inst);
  assign f7  = f_funct7(if_inst);
  assign rs1 = f_rs1(if_inst);
  assign rs2 = f_rs2(if_inst);
  assign rd  = f_rd(if_inst);

  regfile #(.XLEN(XLEN), .NREG(NR)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra1(rs1), .ra2(rs2), .rd1(rs1_data), .rd2(rs2_data),
    .we(wb_en), .wa(wb_rd), .wd(wb_data)
  );

  always_comb begin
    dec       = '0;
    legal_fmt = 1'b0;
    dec.pc    = if_pc;
    dec.rd    = rd;
    case (opc)
      OPC_OP: begin
        dec.op     = 1'b1;
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.a      = rs1_data;
        dec.b      = rs2_data;
        legal_fmt  = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_OP_IMM: begin
        dec.op_imm = 1'b1;
        dec.funct3 = f3;
        dec.a      = rs1_data;
        if (f3 == F3_SLLI || f3 == F3_SRI) begin
          // shifts carry the shamt in rs2's slot and a real funct7
          dec.b     = {27'b0, rs2};
          dec.funct7 = f7;
          legal_fmt = (f7 == F7_BASE) || (f7 == F7_ALT && f3 == F3_SRI);
        end else begin
          dec.b     = imm_i(if_inst);
          legal_fmt = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.op_imm = 1'b1;
        dec.b      = imm_u(if_inst);
        legal_fmt  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op_imm = 1'b1;
        dec.a      = if_pc;
        dec.b      = imm_u(if_inst);
        legal_fmt  = 1'b1;
      end
      default: legal_fmt = 1'b0;
    endcase
    dec.illegal = !legal;
    dec.rd_we   = legal && (rd != 5'd0);
  end

`ifdef RV32E_EN
  logic e_bad;
  // only the register fields the format actually uses are range-checked
  always_comb begin
    e_bad = 1'b0;
    case (opc)
      OPC_OP:              e_bad = rs1[4] | rs2[4] | rd[4];
      OPC_OP_IMM:          e_bad = rs1[4] | rd[4];
      OPC_LUI, OPC_AUIPC:  e_bad = rd[4];
      default:             e_bad = 1'b0;
    endcase
  end
  assign legal = legal_fmt & !e_bad;
`else
  assign legal = legal_fmt;
`endif

  assign if_ready = !vld_q | ex_ready | flush;
  assign cap      = if_valid & if_ready & !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ex_q  <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (cap) begin
      vld_q <= 1'b1;
      ex_q  <= dec;
    end else if (ex_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign ex_valid   = vld_q;
  assign ex_op      = ex_q.op;
  assign ex_op_imm  = ex_q.op_imm;
  assign ex_funct3  = ex_q.funct3;
  assign ex_funct7  = ex_q.funct7;
  assign ex_a       = ex_q.a;
  assign ex_b       = ex_q.b;
  assign ex_rd      = ex_q.rd;
  assign ex_rd_we   = ex_q.rd_we;
  assign ex_pc      = ex_q.pc;
  assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus stall, flush and
// asynchronous reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready, flush, wb_en, ex_valid, ex_ready;
  logic [31:0] if_pc, if_inst, wb_data;
  logic [4:0]  wb_rd;
  logic        ex_op, ex_op_imm, ex_rd_we, ex_illegal;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [31:0] ex_a, ex_b, ex_pc;
  logic [4:0]  ex_rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_op_imm(ex_op_imm),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [18:0] ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  // {op, op_imm, funct3, funct7, rd, rd_we, illegal}
  function automatic logic [18:0] mk(input logic op, input logic opi, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [4:0] rd,
                                     input logic we, input logic ill);
    return {op, opi, f3, f7, rd, we, ill};
  endfunction

  function automatic logic [18:0] act_ctrl();
    return {ex_op, ex_op_imm, ex_funct3, ex_funct7, ex_rd, ex_rd_we, ex_illegal};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    vt[0]  = '{32'hFFF28313, 32'h100, 1'b0, 5'd0, 32'h0,        mk(0,1,3'd0,7'h00,5'd6, 1,0), 32'h10,        32'hFFFFFFFF};
    vt[1]  = '{32'h40315093, 32'h104, 1'b0, 5'd0, 32'h0,        mk(0,1,3'd5,7'h20,5'd1, 1,0), 32'h80000000,  32'h3};
    vt[2]  = '{32'h00311093, 32'h108, 1'b0, 5'd0, 32'h0,        mk(0,1,3'd1,7'h00,5'd1, 1,0), 32'h80000000,  32'h3};
    vt[3]  = '{32'h40038433, 32'h10C, 1'b1, 5'd7, 32'hDEADBEEF, mk(1,0,3'd0,7'h20,5'd8, 1,0), 32'hDEADBEEF,  32'h0};
    vt[4]  = '{32'h00000073, 32'h110, 1'b0, 5'd0, 32'h0,        mk(0,0,3'd0,7'h00,5'd0, 0,1), 32'h0,         32'h0};
    vt[5]  = '{32'hABCDE1B7, 32'h114, 1'b0, 5'd0, 32'h0,        mk(0,1,3'd0,7'h00,5'd3, 1,0), 32'h0,         32'hABCDE000};
    vt[6]  = '{32'h00001217, 32'h200, 1'b0, 5'd0, 32'h0,        mk(0,1,3'd0,7'h00,5'd4, 1,0), 32'h200,       32'h1000};
    vt[7]  = '{32'h402294B3, 32'h204, 1'b0, 5'd0, 32'h0,        mk(1,0,3'd1,7'h20,5'd9, 0,1), 32'h10,        32'h80000000};
    vt[8]  = '{32'h00208033, 32'h208, 1'b0, 5'd0, 32'h0,        mk(1,0,3'd0,7'h00,5'd0, 0,0), 32'h11,        32'h80000000};
    vt[9]  = '{32'h40311093, 32'h20C, 1'b0, 5'd0, 32'h0,        mk(0,1,3'd1,7'h20,5'd1, 0,1), 32'h80000000,  32'h3};
    vt[10] = '{32'h00500513, 32'h210, 1'b1, 5'd0, 32'h0000FFFF, mk(0,1,3'd0,7'h00,5'd10,1,0), 32'h0,         32'h5};
    vt[11] = '{32'h7FF38613, 32'h214, 1'b0, 5'd0, 32'h0,        mk(0,1,3'd0,7'h00,5'd12,1,0), 32'hDEADBEEF,  32'h7FF};
`ifdef RV32E_EN
    vt[12] = '{32'h00208833, 32'h218, 1'b0, 5'd0, 32'h0,        mk(1,0,3'd0,7'h00,5'd16,0,1), 32'h11,        32'h80000000};
`else
    vt[12] = '{32'h00208833, 32'h218, 1'b0, 5'd0, 32'h0,        mk(1,0,3'd0,7'h00,5'd16,1,0), 32'h11,        32'h80000000};
`endif

    rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
    #3;
    chk("rst.ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst.if_ready", {31'b0, if_ready}, 32'd1);
    chk("rst.ctrl", {13'b0, act_ctrl()}, 32'd0);
    chk("rst.ex_a", ex_a, 32'd0);
    chk("rst.ex_b", ex_b, 32'd0);
    chk("rst.ex_pc", ex_pc, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    wb(5'd5, 32'h10);
    wb(5'd2, 32'h80000000);
    wb(5'd1, 32'h11);

    for (int i = 0; i < NV; i++) begin
      if_valid = 1'b1; if_inst = vt[i].inst; if_pc = vt[i].pc;
      wb_en = vt[i].wb_en; wb_rd = vt[i].wb_rd; wb_data = vt[i].wb_data;
      step();
      wb_en = 1'b0; if_valid = 1'b0;
      chk($sformatf("vec%0d.valid", i), {31'b0, ex_valid}, 32'd1);
      chk($sformatf("vec%0d.ctrl", i), {13'b0, act_ctrl()}, {13'b0, vt[i].ctrl});
      chk($sformatf("vec%0d.a", i), ex_a, vt[i].a);
      chk($sformatf("vec%0d.b", i), ex_b, vt[i].b);
      chk($sformatf("vec%0d.pc", i), ex_pc, vt[i].pc);
    end

    // back-pressure: hold bundle for 3 cycles, then accept the waiting one
    if_valid = 1'b1; if_inst = 32'hFFF28313; if_pc = 32'h2F0;
    step();
    chk("stall.first_rd", {27'b0, ex_rd}, 32'd6);
    ex_ready = 1'b0; if_inst = 32'hABCDE1B7; if_pc = 32'h300;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d.valid", k), {31'b0, ex_valid}, 32'd1);
      chk($sformatf("stall%0d.if_ready", k), {31'b0, if_ready}, 32'd0);
      chk($sformatf("stall%0d.rd", k), {27'b0, ex_rd}, 32'd6);
      chk($sformatf("stall%0d.b", k), ex_b, 32'hFFFFFFFF);
      chk($sformatf("stall%0d.pc", k), ex_pc, 32'h2F0);
    end
    ex_ready = 1'b1;
    #1;
    chk("release.if_ready", {31'b0, if_ready}, 32'd1);
    step();
    if_valid = 1'b0;
    chk("release.valid", {31'b0, ex_valid}, 32'd1);
    chk("release.rd", {27'b0, ex_rd}, 32'd3);
    chk("release.pc", ex_pc, 32'h300);
    step();
    chk("release.no_dup", {31'b0, ex_valid}, 32'd0);

    // flush kills the held bundle and drops the one offered alongside
    if_valid = 1'b1; if_inst = 32'hFFF28313; if_pc = 32'h400; ex_ready = 1'b0;
    step();
    chk("flush.pre_valid", {31'b0, ex_valid}, 32'd1);
    flush = 1'b1; if_inst = 32'hABCDE1B7; if_pc = 32'h404;
    #1;
    chk("flush.if_ready", {31'b0, if_ready}, 32'd1);
    step();
    chk("flush.valid", {31'b0, ex_valid}, 32'd0);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    step();
    chk("flush.dropped", {31'b0, ex_valid}, 32'd0);

    // asynchronous reset mid-operation, register file cleared afterwards
    if_valid = 1'b1; if_inst = 32'hFFF28313; if_pc = 32'h500;
    step();
    if_valid = 1'b0;
    chk("arst.pre_a", ex_a, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'b0, ex_valid}, 32'd0);
    chk("arst.a", ex_a, 32'd0);
    chk("arst.ctrl", {13'b0, act_ctrl()}, 32'd0);
    step();
    rst_n = 1'b1;
    if_valid = 1'b1;
    step();
    if_valid = 1'b0;
    chk("arst.rf_cleared_a", ex_a, 32'd0);
    chk("arst.b", ex_b, 32'hFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
